// File: rtl/pipe_hazard_ctrl_if.sv
// Control bundle between the hazard controller and the pipeline datapath.
// The master side drives the ID/EX/MEM hazard inputs; the slave side returns the stall/flush controls.
interface pipe_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_uses_rs1;
  logic                  id_uses_rs2;
  logic                  id_branch;
  logic                  id_branch_taken;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_reg_write;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic                  mem_mem_read;
  logic                  ex_mc_start;

  logic                  pc_we;
  logic                  if_id_we;
  logic                  if_id_flush;
  logic                  id_ex_bubble;
  logic                  ex_hold;
  logic                  mc_busy;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_branch, id_branch_taken,
    output ex_rd, ex_reg_write, ex_mem_read, mem_rd, mem_mem_read, ex_mc_start,
    input  pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_hold, mc_busy,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_branch, id_branch_taken,
    input  ex_rd, ex_reg_write, ex_mem_read, mem_rd, mem_mem_read, ex_mc_start,
    output pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_hold, mc_busy,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller: load-use and branch-operand stalls, taken-branch IF flush, multicycle EX freeze.
// Controls are combinational from state and inputs; FSM and saturating perf counters update on clk.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MC_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int MC_W = $clog2(MC_LATENCY) + 1;
  localparam logic [MC_W-1:0]  MC_INIT = MC_W'(MC_LATENCY - 1);
  localparam logic [MC_W-1:0]  MC_ONE  = MC_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {RUN, MC_BUSY} state_t;

  state_t           state_q, state_d;
  logic [MC_W-1:0]  mc_cnt_q, mc_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_hold;
  logic mc_hold, hazard;
  logic ex_match, mem_match;

  // x0 is hard-wired zero, so it never creates a dependency.
  function automatic logic src_match(
    input logic [REG_ADDR_W-1:0] idx,
    input logic [REG_ADDR_W-1:0] rs1,
    input logic [REG_ADDR_W-1:0] rs2,
    input logic                  use1,
    input logic                  use2
  );
    return (idx != '0) && ((use1 && (rs1 == idx)) || (use2 && (rs2 == idx)));
  endfunction

  always_comb begin
    ex_match  = src_match(bus.ex_rd, bus.id_rs1, bus.id_rs2, bus.id_uses_rs1, bus.id_uses_rs2);
    mem_match = src_match(bus.mem_rd, bus.id_rs1, bus.id_rs2, bus.id_uses_rs1, bus.id_uses_rs2);

    mc_hold = ((state_q == RUN) && bus.ex_mc_start) ||
              ((state_q == MC_BUSY) && (mc_cnt_q > MC_ONE));

    hazard = (bus.ex_mem_read && ex_match) ||
             (bus.id_branch && bus.ex_reg_write && ex_match) ||
             (bus.id_branch && bus.mem_mem_read && mem_match);

    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_hold      = 1'b0;
    if (reset) begin
      pc_we = 1'b1;
    end else if (mc_hold) begin
      ex_hold  = 1'b1;
      pc_we    = 1'b0;
      if_id_we = 1'b0;
    end else if (hazard) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (bus.id_branch && bus.id_branch_taken) begin
      if_id_flush = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    mc_cnt_d    = mc_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (reset) begin
      state_d     = RUN;
      mc_cnt_d    = '0;
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.ex_mc_start) begin
            state_d  = MC_BUSY;
            mc_cnt_d = MC_INIT;
          end
        end
        MC_BUSY: begin
          // ex_mc_start is deliberately ignored until the current op drains.
          if (mc_cnt_q > MC_ONE) begin
            mc_cnt_d = mc_cnt_q - MC_ONE;
          end else begin
            state_d  = RUN;
            mc_cnt_d = '0;
          end
        end
        default: begin
          state_d  = RUN;
          mc_cnt_d = '0;
        end
      endcase
      if (!pc_we && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + 1'b1;
      if (if_id_flush && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    state_q     <= state_d;
    mc_cnt_q    <= mc_cnt_d;
    stall_cnt_q <= stall_cnt_d;
    flush_cnt_q <= flush_cnt_d;
  end

  assign bus.pc_we        = pc_we;
  assign bus.if_id_we     = if_id_we;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_bubble = id_ex_bubble;
  assign bus.ex_hold      = ex_hold;
  assign bus.mc_busy      = (state_q == MC_BUSY);
  assign bus.stall_cnt    = stall_cnt_q;
  assign bus.flush_cnt    = flush_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: u_a uses 16-bit counters, u_b shares the same inputs with 2-bit counters.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(16)) bus_a ();
  pipe_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(2))  bus_b ();

  assign bus_b.id_rs1          = bus_a.id_rs1;
  assign bus_b.id_rs2          = bus_a.id_rs2;
  assign bus_b.id_uses_rs1     = bus_a.id_uses_rs1;
  assign bus_b.id_uses_rs2     = bus_a.id_uses_rs2;
  assign bus_b.id_branch       = bus_a.id_branch;
  assign bus_b.id_branch_taken = bus_a.id_branch_taken;
  assign bus_b.ex_rd           = bus_a.ex_rd;
  assign bus_b.ex_reg_write    = bus_a.ex_reg_write;
  assign bus_b.ex_mem_read     = bus_a.ex_mem_read;
  assign bus_b.mem_rd          = bus_a.mem_rd;
  assign bus_b.mem_mem_read    = bus_a.mem_mem_read;
  assign bus_b.ex_mc_start     = bus_a.ex_mc_start;

  pipe_hazard_ctrl #(.REG_ADDR_W(5), .MC_LATENCY(4), .CNT_W(16)) u_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave));
  pipe_hazard_ctrl #(.REG_ADDR_W(5), .MC_LATENCY(4), .CNT_W(2)) u_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Order: pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_hold
  task automatic chk_ctrl(input string tag, input logic [4:0] exp);
    chk({tag, ".pc_we"},        32'(bus_a.pc_we),        32'(exp[4]));
    chk({tag, ".if_id_we"},     32'(bus_a.if_id_we),     32'(exp[3]));
    chk({tag, ".if_id_flush"},  32'(bus_a.if_id_flush),  32'(exp[2]));
    chk({tag, ".id_ex_bubble"}, 32'(bus_a.id_ex_bubble), 32'(exp[1]));
    chk({tag, ".ex_hold"},      32'(bus_a.ex_hold),      32'(exp[0]));
  endtask

  task automatic idle_inputs();
    bus_a.id_rs1 = '0;          bus_a.id_rs2 = '0;
    bus_a.id_uses_rs1 = 1'b0;   bus_a.id_uses_rs2 = 1'b0;
    bus_a.id_branch = 1'b0;     bus_a.id_branch_taken = 1'b0;
    bus_a.ex_rd = '0;           bus_a.ex_reg_write = 1'b0;
    bus_a.ex_mem_read = 1'b0;   bus_a.mem_rd = '0;
    bus_a.mem_mem_read = 1'b0;  bus_a.ex_mc_start = 1'b0;
  endtask

  task automatic load_use();
    idle_inputs();
    bus_a.ex_mem_read = 1'b1; bus_a.ex_rd = 5'd5;
    bus_a.id_rs2 = 5'd5;      bus_a.id_uses_rs2 = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [4:0] NORMAL = 5'b11000;
  localparam logic [4:0] STALL  = 5'b00010;
  localparam logic [4:0] FLUSH  = 5'b11100;
  localparam logic [4:0] HOLD   = 5'b00001;

  initial begin
    reset = 1'b1;
    idle_inputs();
    bus_a.ex_mc_start = 1'b1;
    bus_a.ex_mem_read = 1'b1;
    #1;
    chk_ctrl("reset_idle", NORMAL);
    tick();
    tick();
    idle_inputs();
    #1;
    chk("reset.mc_busy", 32'(bus_a.mc_busy), 32'd0);
    chk("reset.stall_cnt", 32'(bus_a.stall_cnt), 32'd0);
    chk("reset.flush_cnt", 32'(bus_a.flush_cnt), 32'd0);
    reset = 1'b0;
    #1;
    chk_ctrl("run_idle", NORMAL);

    // Load-use on rs2
    load_use();
    #1;
    chk_ctrl("load_use", STALL);
    tick();
    idle_inputs();
    #1;
    chk("load_use.stall_cnt", 32'(bus_a.stall_cnt), 32'd1);
    chk_ctrl("after_load_use", NORMAL);

    // x0 and unused-source cases never stall
    bus_a.ex_mem_read = 1'b1; bus_a.ex_rd = 5'd0; bus_a.id_rs1 = 5'd0; bus_a.id_uses_rs1 = 1'b1;
    #1;
    chk_ctrl("x0_no_stall", NORMAL);
    bus_a.ex_rd = 5'd7; bus_a.id_rs1 = 5'd7; bus_a.id_uses_rs1 = 1'b0;
    #1;
    chk_ctrl("unused_rs1", NORMAL);
    idle_inputs();
    bus_a.ex_reg_write = 1'b1; bus_a.ex_rd = 5'd4; bus_a.id_rs1 = 5'd4; bus_a.id_uses_rs1 = 1'b1;
    #1;
    chk_ctrl("alu_dep_no_branch", NORMAL);
    tick();
    chk("no_stall.stall_cnt", 32'(bus_a.stall_cnt), 32'd1);

    // Taken branch waiting on EX result, then flush once resolved
    idle_inputs();
    bus_a.id_branch = 1'b1; bus_a.id_branch_taken = 1'b1;
    bus_a.ex_reg_write = 1'b1; bus_a.ex_rd = 5'd3; bus_a.id_rs1 = 5'd3; bus_a.id_uses_rs1 = 1'b1;
    #1;
    chk_ctrl("branch_ex_dep", STALL);
    tick();
    chk("branch_ex_dep.stall_cnt", 32'(bus_a.stall_cnt), 32'd2);
    bus_a.ex_reg_write = 1'b0;
    #1;
    chk_ctrl("branch_flush", FLUSH);
    tick();
    chk("branch_flush.flush_cnt", 32'(bus_a.flush_cnt), 32'd1);
    chk("branch_flush.stall_cnt", 32'(bus_a.stall_cnt), 32'd2);

    // Branch waiting on a MEM-stage load; same load without a branch is harmless
    idle_inputs();
    bus_a.id_branch = 1'b1; bus_a.mem_mem_read = 1'b1; bus_a.mem_rd = 5'd9;
    bus_a.id_rs2 = 5'd9; bus_a.id_uses_rs2 = 1'b1;
    #1;
    chk_ctrl("branch_mem_dep", STALL);
    bus_a.id_branch = 1'b0;
    #1;
    chk_ctrl("mem_load_no_branch", NORMAL);
    bus_a.id_branch = 1'b1;
    tick();
    chk("branch_mem_dep.stall_cnt", 32'(bus_a.stall_cnt), 32'd3);
    bus_a.mem_mem_read = 1'b0;
    #1;
    chk_ctrl("branch_not_taken", NORMAL);

    // Multicycle op, latency 4: start + two held busy cycles, then a released busy cycle
    idle_inputs();
    bus_a.ex_mc_start = 1'b1;
    load_use();
    bus_a.ex_mc_start = 1'b1;
    #1;
    chk_ctrl("mc_start", HOLD);
    chk("mc_start.mc_busy", 32'(bus_a.mc_busy), 32'd0);
    tick();
    idle_inputs();
    #1;
    chk("mc_busy1.mc_busy", 32'(bus_a.mc_busy), 32'd1);
    chk_ctrl("mc_busy1", HOLD);
    tick();
    bus_a.ex_mc_start = 1'b1;
    #1;
    chk("mc_busy2.mc_busy", 32'(bus_a.mc_busy), 32'd1);
    chk_ctrl("mc_busy2_restart_ignored", HOLD);
    tick();
    idle_inputs();
    #1;
    chk("mc_busy3.mc_busy", 32'(bus_a.mc_busy), 32'd1);
    chk_ctrl("mc_busy3_released", NORMAL);
    load_use();
    #1;
    chk_ctrl("mc_busy3_hazard", STALL);
    idle_inputs();
    tick();
    chk("mc_done.mc_busy", 32'(bus_a.mc_busy), 32'd0);
    chk("mc_done.stall_cnt", 32'(bus_a.stall_cnt), 32'd6);
    chk_ctrl("mc_done", NORMAL);

    // Reset in the second busy cycle aborts the op
    bus_a.ex_mc_start = 1'b1;
    tick();
    idle_inputs();
    tick();
    #1;
    chk("mc_abort.busy_before", 32'(bus_a.mc_busy), 32'd1);
    chk_ctrl("mc_abort.held", HOLD);
    reset = 1'b1;
    #1;
    chk_ctrl("mc_abort.reset_idle", NORMAL);
    tick();
    reset = 1'b0;
    #1;
    chk("mc_abort.mc_busy", 32'(bus_a.mc_busy), 32'd0);
    chk("mc_abort.stall_cnt", 32'(bus_a.stall_cnt), 32'd0);
    chk("mc_abort.flush_cnt", 32'(bus_a.flush_cnt), 32'd0);
    chk_ctrl("mc_abort.run", NORMAL);
    tick();
    chk("mc_abort.stays_run", 32'(bus_a.mc_busy), 32'd0);

    // Five back-to-back load-use stalls: 2-bit counter saturates at 3
    load_use();
    tick();
    chk("sat.stall_cnt_1", 32'(bus_b.stall_cnt), 32'd1);
    tick();
    chk("sat.stall_cnt_2", 32'(bus_b.stall_cnt), 32'd2);
    tick();
    chk("sat.stall_cnt_3", 32'(bus_b.stall_cnt), 32'd3);
    tick();
    chk("sat.stall_cnt_4", 32'(bus_b.stall_cnt), 32'd3);
    tick();
    chk("sat.stall_cnt_5", 32'(bus_b.stall_cnt), 32'd3);
    chk("sat.wide_stall_cnt", 32'(bus_a.stall_cnt), 32'd5);

    // Flush counter saturation on the 2-bit instance
    idle_inputs();
    bus_a.id_branch = 1'b1; bus_a.id_branch_taken = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("sat.flush_cnt_b", 32'(bus_b.flush_cnt), 32'd3);
    chk("sat.flush_cnt_a", 32'(bus_a.flush_cnt), 32'd4);
    idle_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised hazard and stall controller for the 5-stage pipeline. It adds the behaviours the current datapath lacks: load-use stalls, stalls when an ID-stage branch compare depends on EX/MEM results, flushing of the fetched instruction on a taken branch, and a freeze FSM for multicycle EX operations. It sits beside the forwarding unit and drives the PC, IF_ID and ID_EX write/flush controls. It also provides saturating stall and flush performance counters.

Parameters:
REG_ADDR_W, 5, register-index width
MC_LATENCY, 4, total EX occupancy in cycles of a multicycle op; must be >=2
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
id_rs1  in  REG_ADDR_W  rs1 index of the instruction in ID
id_rs2  in  REG_ADDR_W  rs2 index of the instruction in ID
id_uses_rs1  in  1  the ID instruction reads rs1
id_uses_rs2  in  1  the ID instruction reads rs2
id_branch  in  1  the ID instruction is a branch
id_branch_taken  in  1  ID compare result: branch taken
ex_rd  in  REG_ADDR_W  destination of the ID_EX instruction
ex_reg_write  in  1  the ID_EX instruction writes a register
ex_mem_read  in  1  the ID_EX instruction is a load
mem_rd  in  REG_ADDR_W  destination of the EX_MEM instruction
mem_mem_read  in  1  the EX_MEM instruction is a load
ex_mc_start  in  1  a multicycle op occupies EX in its first cycle
pc_we  out  1  PC write enable
if_id_we  out  1  IF_ID write enable
if_id_flush  out  1  zero IF_ID at the next edge
id_ex_bubble  out  1  load NOPs into the ID_EX control fields
ex_hold  out  1  freeze ID_EX and insert a bubble into EX_MEM
mc_busy  out  1  FSM is in MC_BUSY
stall_cnt  out  CNT_W  count of cycles with pc_we=0
flush_cnt  out  CNT_W  count of cycles with if_id_flush=1

Behaviour:
- States: RUN and MC_BUSY, plus a down-counter mc_cnt (width clog2(MC_LATENCY)+1).
- Reset (sync, high):
  - Next edge: state=RUN, mc_cnt=0, stall_cnt=0, flush_cnt=0.
  - While reset=1, outputs are forced idle: pc_we=1, if_id_we=1, if_id_flush=0, id_ex_bubble=0, ex_hold=0.
  - Reset during MC_BUSY aborts the op.
- Control outputs are combinational from state and inputs (zero latency). Counters and state update on the rising edge of clk.
- Multicycle op (highest priority):
  - RUN with ex_mc_start=1: ex_hold=1, pc_we=0, if_id_we=0, id_ex_bubble=0, if_id_flush=0. Next edge: state=MC_BUSY, mc_cnt=MC_LATENCY-1.
  - MC_BUSY with mc_cnt>1: same outputs as the start cycle; mc_cnt decrements.
  - MC_BUSY with mc_cnt==1: ex_hold=0; hazard logic below applies normally; next state=RUN.
  - ex_hold is therefore high for exactly MC_LATENCY-1 cycles, and EX occupancy is MC_LATENCY cycles.
  - ex_mc_start is ignored while in MC_BUSY.
- Data hazard (evaluated when not held by the multicycle op):
  - A match means idx!=0 and idx equals a used ID source (id_uses_rsN=1 and id_rsN==idx).
  - Load-use: ex_mem_read=1 and ex_rd matches.
  - Branch operand from EX: id_branch=1, ex_reg_write=1, and ex_rd matches.
  - Branch operand from a MEM load: id_branch=1, mem_mem_read=1, and mem_rd matches.
  - Any of the three: pc_we=0, if_id_we=0, id_ex_bubble=1, if_id_flush=0.
- Branch flush: if there is no stall or hold and id_branch=1 and id_branch_taken=1, then if_id_flush=1 with pc_we=1 and if_id_we=1. Flush overrides the IF_ID write.
- Otherwise: pc_we=1, if_id_we=1, and all other control outputs are 0.
- Register x0 never causes a hazard.
- Counters: stall_cnt increments on each non-reset cycle with pc_we=0; flush_cnt increments on each cycle with if_id_flush=1. Both saturate at 2^CNT_W-1 and do not wrap.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> one cycle of pc_we=0, if_id_we=0, id_ex_bubble=1; stall_cnt 0->1.
- x0 and unused source: ex_mem_read=1, ex_rd=0, id_rs1=0 -> no stall. Also ex_rd=7, id_rs1=7, id_uses_rs1=0 -> no stall.
- Branch dependency: id_branch=1, id_branch_taken=1, ex_reg_write=1, ex_rd=3=id_rs1 -> stall and if_id_flush=0. The next cycle without a match -> if_id_flush=1, flush_cnt=1.
- Multicycle, MC_LATENCY=4: ex_mc_start pulse -> ex_hold=1 for 3 cycles, mc_busy=1 for 3 cycles, then RUN; stall_cnt=3. A second ex_mc_start during busy is ignored.
- Reset mid-op: reset asserted in the 2nd MC_BUSY cycle -> outputs idle immediately; after the edge mc_busy=0 and both counters=0.
- Saturation with CNT_W=2: 5 consecutive load-use stalls -> stall_cnt goes 1, 2, 3, 3, 3.
